// File: rtl/ulpi_reg_access_pkg.sv
// ULPI register-access shared definitions: TX CMD prefixes, idle byte,
// FSM state codes and the register command byte builder. Also usable by
// the receive path.
package ulpi_reg_access_pkg;

  localparam logic [1:0] ULPI_REGW      = 2'b10;
  localparam logic [1:0] ULPI_REGR      = 2'b11;
  localparam logic [7:0] ULPI_IDLE_BYTE = 8'h00;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_RTURN = 3'd4;
  localparam logic [2:0] ST_RDATA = 3'd5;
  localparam logic [2:0] ST_RWAIT = 3'd6;

  // TX CMD byte for an immediate register access.
  function automatic logic [7:0] ulpi_reg_cmd(input logic we, input logic [5:0] addr);
    return {(we ? ULPI_REGW : ULPI_REGR), addr};
  endfunction

endpackage

// File: rtl/ulpi_reg_access_if.sv
// Request/response handshake and ULPI link-side pins of the register
// access engine. slave = engine view, master = requester/PHY view.
interface ulpi_reg_access_if;

  logic       req;
  logic       we;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] rdata;

  logic       DIR;
  logic       NXT;
  logic [7:0] DATA_I;
  logic [7:0] DATA_O;
  logic       DATA_OE;
  logic       STP;

  modport slave (
    input  req, we, addr, wdata, DIR, NXT, DATA_I,
    output busy, done, aborted, rdata, DATA_O, DATA_OE, STP
  );

  modport master (
    output req, we, addr, wdata, DIR, NXT, DATA_I,
    input  busy, done, aborted, rdata, DATA_O, DATA_OE, STP
  );

endinterface

// File: rtl/ulpi_reg_access.sv
// ULPI immediate register read/write engine for the USB3300 link.
// All outputs are registered and decoded from the next state, so a
// PHY abort (DIR rising) releases the bus on the following cycle.
module ulpi_reg_access
  import ulpi_reg_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  ulpi_reg_access_if.slave   bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic       r_we;
  logic [5:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic [7:0] r_data_o;
  logic       r_oe;
  logic       r_stp;
  logic       r_busy;
  logic       r_done;
  logic       r_aborted;

  logic [2:0] w_next;
  logic       w_accept;
  logic       w_capture;
  logic       w_done;
  logic       w_abort;
  logic       w_tmo;
  logic       w_cnt_en;
  logic [7:0] w_data_o;
  logic       w_oe;

  assign w_tmo    = (r_cnt == TMO_LAST);
  assign w_cnt_en = (r_state == ST_CMD) || (r_state == ST_WDATA) ||
                    (r_state == ST_RTURN) || (r_state == ST_RWAIT);

  // Next-state selection; PHY events take priority over the timeout.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req && !bus.DIR) begin
          w_accept = 1'b1;
          w_next   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (bus.DIR)      w_abort = 1'b1;
        else if (bus.NXT) w_next  = r_we ? ST_WDATA : ST_RTURN;
        else if (w_tmo)   w_abort = 1'b1;
      end
      ST_WDATA: begin
        if (bus.DIR)      w_abort = 1'b1;
        else if (bus.NXT) w_next  = ST_STOP;
        else if (w_tmo)   w_abort = 1'b1;
      end
      ST_STOP: begin
        w_next = ST_IDLE;
        w_done = 1'b1;
      end
      ST_RTURN: begin
        if (bus.DIR)    w_next  = ST_RDATA;
        else if (w_tmo) w_abort = 1'b1;
      end
      ST_RDATA: begin
        // Anything but DIR=1/NXT=0 means the PHY did not return register data.
        if (bus.DIR && !bus.NXT) begin
          w_capture = 1'b1;
          w_next    = ST_RWAIT;
        end else begin
          w_abort = 1'b1;
        end
      end
      ST_RWAIT: begin
        if (!bus.DIR) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end else if (w_tmo) begin
          w_abort = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  // Bus drive decoded from the state being entered.
  always_comb begin
    w_data_o = ULPI_IDLE_BYTE;
    w_oe     = 1'b0;
    case (w_next)
      ST_IDLE: w_oe = !bus.DIR;
      ST_CMD: begin
        w_oe     = 1'b1;
        w_data_o = w_accept ? ulpi_reg_cmd(bus.we, bus.addr) : ulpi_reg_cmd(r_we, r_addr);
      end
      ST_WDATA: begin
        w_oe     = 1'b1;
        w_data_o = r_wdata;
      end
      ST_STOP: w_oe = 1'b1;
      default: ;
    endcase
  end

  // FSM state, registered outputs and the per-state timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_data_o  <= ULPI_IDLE_BYTE;
      r_oe      <= 1'b0;
      r_stp     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_data_o  <= w_data_o;
      r_oe      <= w_oe;
      r_stp     <= (w_next == ST_STOP);
      r_busy    <= (w_next != ST_IDLE);
      r_done    <= w_done;
      r_aborted <= w_abort;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_cnt_en)     r_cnt <= r_cnt + 8'd1;
    end
  end

  // Request latch and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (w_capture) r_rdata <= bus.DATA_I;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.aborted = r_aborted;
  assign bus.rdata   = r_rdata;
  assign bus.DATA_O  = r_data_o;
  assign bus.DATA_OE = r_oe;
  assign bus.STP     = r_stp;

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Bench for ulpi_reg_access: per-cycle vectors built from transaction
// descriptions (directed + random), plus an async reset sequence.
module tb_ulpi_reg_access;

  localparam int unsigned TO = 16;

  typedef struct {
    logic        req;
    logic        we;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic        dir;
    logic        nxt;
    logic [7:0]  di;
    logic [20:0] exp;   // {busy, done, aborted, rdata, DATA_O, DATA_OE, STP}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  ulpi_reg_access_if u_if ();

  ulpi_reg_access #(.TIMEOUT(TO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  vec_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference state carried across cycles.
  logic [7:0] m_rdata     = 8'h00;
  logic       m_prev_dir  = 1'b0;
  logic       m_pend_done = 1'b0;
  logic       m_pend_ab   = 1'b0;

  function automatic logic [20:0] act();
    return {u_if.busy, u_if.done, u_if.aborted, u_if.rdata,
            u_if.DATA_O, u_if.DATA_OE, u_if.STP};
  endfunction

  task automatic check(input string nm, input int idx, input logic [20:0] got, input logic [20:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s #%0d: got {busy,done,ab,rdata,dout,oe,stp}=%b_%b_%b_%h_%h_%b_%b expected %b_%b_%b_%h_%h_%b_%b",
               nm, idx, got[20], got[19], got[18], got[17:10], got[9:2], got[1], got[0],
               exp[20], exp[19], exp[18], exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // One cycle: inputs driven this cycle, outputs expected this cycle.
  task automatic emit(input logic req, input logic we, input logic [5:0] a, input logic [7:0] wd,
                      input logic dir, input logic nxt, input logic [7:0] di,
                      input logic busy, input logic [7:0] dout, input logic oe, input logic stp);
    vec_t v;
    v.req = req; v.we = we; v.addr = a; v.wdata = wd;
    v.dir = dir; v.nxt = nxt; v.di = di;
    v.exp = {busy, m_pend_done, m_pend_ab, m_rdata, dout, (busy ? oe : !m_prev_dir), stp};
    q.push_back(v);
    m_prev_dir  = dir;
    m_pend_done = 1'b0;
    m_pend_ab   = 1'b0;
  endtask

  task automatic eb(input logic dir, input logic nxt, input logic [7:0] di,
                    input logic [7:0] dout, input logic oe, input logic stp);
    emit(1'b0, 1'($urandom), 6'($urandom), 8'($urandom), dir, nxt, di, 1'b1, dout, oe, stp);
  endtask

  task automatic idle_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      emit(1'b0, 1'($urandom), 6'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0),
           1'($urandom), 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // mode: 0 ok, 1 DIR in CMD, 2 DIR in WDATA, 3 CMD timeout
  task automatic tx_write(input logic [5:0] a, input logic [7:0] wd, input int unsigned hold,
                          input int unsigned d1, input int unsigned d2,
                          input int unsigned mode, input int unsigned ab_at);
    logic [7:0] cmd;
    cmd = {2'b10, a};
    for (int unsigned i = 0; i < hold; i++)
      emit(1'b1, 1'b1, a, wd, 1'b1, 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
    emit(1'b1, 1'b1, a, wd, 1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
    if (mode == 3) begin
      for (int unsigned c = 0; c < TO; c++) eb(1'b0, 1'b0, 8'($urandom), cmd, 1'b1, 1'b0);
      m_pend_ab = 1'b1;
      return;
    end
    if (mode == 1) begin
      for (int unsigned c = 0; c < ab_at; c++) eb(1'b0, 1'b0, 8'($urandom), cmd, 1'b1, 1'b0);
      eb(1'b1, 1'($urandom), 8'($urandom), cmd, 1'b1, 1'b0);
      m_pend_ab = 1'b1;
      return;
    end
    for (int unsigned c = 0; c <= d1; c++) eb(1'b0, (c == d1), 8'($urandom), cmd, 1'b1, 1'b0);
    if (mode == 2) begin
      for (int unsigned w = 0; w < ab_at; w++) eb(1'b0, 1'b0, 8'($urandom), wd, 1'b1, 1'b0);
      eb(1'b1, 1'($urandom), 8'($urandom), wd, 1'b1, 1'b0);
      m_pend_ab = 1'b1;
      return;
    end
    for (int unsigned w = 0; w <= d2; w++) eb(1'b0, (w == d2), 8'($urandom), wd, 1'b1, 1'b0);
    eb(1'b0, 1'b0, 8'($urandom), 8'h00, 1'b1, 1'b1);
    m_pend_done = 1'b1;
  endtask

  // mode: 0 ok, 1 DIR in CMD, 3 CMD timeout, 4 NXT in RDATA, 5 turnaround timeout
  task automatic tx_read(input logic [5:0] a, input logic [7:0] data, input int unsigned hold,
                         input int unsigned d1, input int unsigned t, input int unsigned rw,
                         input int unsigned mode, input int unsigned ab_at);
    logic [7:0] cmd;
    cmd = {2'b11, a};
    for (int unsigned i = 0; i < hold; i++)
      emit(1'b1, 1'b0, a, 8'($urandom), 1'b1, 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
    emit(1'b1, 1'b0, a, 8'($urandom), 1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);
    if (mode == 3) begin
      for (int unsigned c = 0; c < TO; c++) eb(1'b0, 1'b0, 8'($urandom), cmd, 1'b1, 1'b0);
      m_pend_ab = 1'b1;
      return;
    end
    if (mode == 1) begin
      for (int unsigned c = 0; c < ab_at; c++) eb(1'b0, 1'b0, 8'($urandom), cmd, 1'b1, 1'b0);
      eb(1'b1, 1'($urandom), 8'($urandom), cmd, 1'b1, 1'b0);
      m_pend_ab = 1'b1;
      return;
    end
    for (int unsigned c = 0; c <= d1; c++) eb(1'b0, (c == d1), 8'($urandom), cmd, 1'b1, 1'b0);
    if (mode == 5) begin
      for (int unsigned j = 0; j < TO; j++) eb(1'b0, 1'b0, 8'($urandom), 8'h00, 1'b0, 1'b0);
      m_pend_ab = 1'b1;
      return;
    end
    for (int unsigned j = 0; j <= t; j++) eb((j == t), 1'b0, 8'($urandom), 8'h00, 1'b0, 1'b0);
    eb(1'b1, (mode == 4), data, 8'h00, 1'b0, 1'b0);
    if (mode == 4) begin
      m_pend_ab = 1'b1;
      return;
    end
    m_rdata = data;
    for (int unsigned k = 0; k <= rw; k++) eb((k != rw), 1'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0);
    m_pend_done = 1'b1;
  endtask

  task automatic apply_q(input string nm);
    foreach (q[i]) begin
      @(posedge clk); #1;
      check(nm, i, act(), q[i].exp);
      u_if.req    = q[i].req;
      u_if.we     = q[i].we;
      u_if.addr   = q[i].addr;
      u_if.wdata  = q[i].wdata;
      u_if.DIR    = q[i].dir;
      u_if.NXT    = q[i].nxt;
      u_if.DATA_I = q[i].di;
    end
    q.delete();
  endtask

  initial begin
    int unsigned kind, d1, d2, t, rw, hold;
    logic [5:0] a;
    logic [7:0] d;

    rst = 1'b1;
    u_if.req = 1'b0; u_if.we = 1'b0; u_if.addr = '0; u_if.wdata = '0;
    u_if.DIR = 1'b0; u_if.NXT = 1'b0; u_if.DATA_I = '0;
    #1 rst = 1'b0;
    #2 check("reset_async", 0, act(), 21'h0);
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 0, act(), 21'h0);
    @(negedge clk) rst = 1'b1;

    // Directed scenarios.
    idle_n(2);
    tx_write(6'h04, 8'h48, 0, 1, 1, 0, 0);   // 84, 48, STP, done
    idle_n(1);
    tx_read(6'h00, 8'h24, 0, 0, 0, 0, 0, 0); // C0, turnaround, rdata 24
    idle_n(1);
    tx_write(6'h0A, 8'h5A, 0, 0, 0, 2, 0);   // DIR in WDATA -> abort
    idle_n(1);
    tx_read(6'h15, 8'h00, 0, 0, 0, 0, 3, 0); // never NXT -> timeout
    idle_n(1);
    tx_write(6'h3F, 8'hC3, 10, 0, 0, 0, 0);  // held off by DIR for 10 cycles
    idle_n(2);
    apply_q("directed");

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      idle_n($urandom_range(0, 2));
      kind = $urandom_range(0, 9);
      a    = 6'($urandom);
      d    = 8'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      d1   = $urandom_range(0, 4);
      d2   = $urandom_range(0, 4);
      t    = $urandom_range(0, 3);
      rw   = $urandom_range(0, 4);
      case (kind)
        0, 1, 2: tx_write(a, d, hold, d1, d2, 0, 0);
        3, 4, 5: tx_read(a, d, hold, d1, t, rw, 0, 0);
        6:       tx_write(a, d, hold, d1, d2, 1, $urandom_range(0, 3));
        7:       tx_write(a, d, hold, d1, d2, 2, $urandom_range(0, 3));
        8:       tx_read(a, d, hold, d1, t, rw, 4, 0);
        default: if ($urandom_range(0, 1) == 0) tx_write(a, d, hold, d1, d2, 3, 0);
                 else tx_read(a, d, hold, d1, t, rw, 5, 0);
      endcase
    end
    idle_n(2);
    apply_q("random");

    // Reset asserted mid-WDATA.
    @(posedge clk); #1;
    u_if.req = 1'b1; u_if.we = 1'b1; u_if.addr = 6'h11; u_if.wdata = 8'hA5;
    u_if.DIR = 1'b0; u_if.NXT = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_cmd", 0, act(), {1'b1, 1'b0, 1'b0, m_rdata, 8'h91, 1'b1, 1'b0});
    u_if.req = 1'b0; u_if.NXT = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_wdata", 0, act(), {1'b1, 1'b0, 1'b0, m_rdata, 8'hA5, 1'b1, 1'b0});
    u_if.NXT = 1'b0;
    #3 rst = 1'b0;
    #1 check("reset_mid_wdata", 0, act(), 21'h0);
    @(posedge clk); #1;
    check("reset_mid_held", 0, act(), 21'h0);
    #2 rst = 1'b1;
    m_rdata = 8'h00; m_prev_dir = 1'b0; m_pend_done = 1'b0; m_pend_ab = 1'b0;
    idle_n(3);
    tx_write(6'h22, 8'h7E, 0, 1, 0, 0, 0);
    idle_n(2);
    apply_q("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
